serial_adder_ctrl: RTL and testbench
====================================

Name: serial_adder_ctrl

Overview:
- Sequencer that performs a WIDTH-bit add with carry-in using one shared two_bit_adder slice, 2 bits per cycle, least-significant pair first.
- Holds operands in shift registers and a carry register between steps.
- Uses a valid/ready handshake on both sides.
- Used wherever a full-width adder is too costly and multi-cycle latency is acceptable.

Parameters:
- WIDTH, 8, operand/result width in bits; must be even and at least 2.
- CNT_W, $clog2(WIDTH/2)+1, width of the step counter; derived, do not override.

Ports:
- clk  input  1  system clock, rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operands a, b, cin are valid.
- in_ready  output  1  controller can accept operands.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in.
- clear  input  1  synchronous abort; discard any operation in flight.
- out_valid  output  1  sum/cout valid.
- out_ready  input  1  consumer accepts the result.
- sum  output  WIDTH  result bits.
- cout  output  1  carry-out of the MSB.
- busy  output  1  high in RUN or DONE.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state=IDLE.
  - in_ready=1, out_valid=0, busy=0, sum=0, cout=0.
  - Internal shift registers, carry register and counter = 0.
- States: IDLE, RUN, DONE.
  - in_ready = (state==IDLE).
  - out_valid = (state==DONE).
  - busy = (state!=IDLE).
- IDLE, on in_valid=1 (accept edge E0):
  - Load a, b into operand shift registers.
  - Load cin into the carry register.
  - Clear the result register; counter=0; go to RUN.
  - in_valid while not IDLE is ignored; no buffering.
- RUN, each edge:
  - Drive the slice with operand bits [1:0] and the carry register.
  - Shift the slice's 2-bit sum into the top of the result register; shift operands right by 2.
  - Capture the slice carry-out into the carry register; counter+1.
  - After the WIDTH/2-th RUN edge, go to DONE.
- Latency: out_valid is high after edge E0+WIDTH/2 (E0+4 for WIDTH=8).
- DONE:
  - sum = result register; cout = carry register.
  - Both are held stable while out_valid=1 and out_ready=0.
  - On out_valid and out_ready, go to IDLE; in_ready rises on the next cycle.
  - Minimum period between accepts is WIDTH/2+2 cycles.
- Arithmetic:
  - {cout,sum} = a + b + cin, modulo 2^(WIDTH+1).
  - Results are exact for all inputs.
- clear:
  - Synchronous; takes priority over all transitions.
  - From any state, go to IDLE on the next edge; out_valid drops and the result is discarded.
  - The sum/cout registers are left unchanged.
- clear together with in_valid in IDLE: clear wins and the operands are not accepted.
- rst_n deasserted mid-RUN: all state clears immediately; no partial result is ever presented.
- Operand changes after the accept edge have no effect.

Decomposition:
- Shared package serial_adder_pkg holds:
  - State encoding enum: IDLE=2'd0, RUN=2'd1, DONE=2'd2.
  - Constant SLICE_W=2.
- One sub-module: the existing two_bit_adder, instantiated once as the datapath slice.
  - The controller adds no arithmetic of its own beyond the counter.

Test Plan:
- Reset: hold rst_n=0 with random inputs -> in_ready=1, out_valid=0, busy=0, sum=0x00, cout=0; release -> still IDLE.
- Basic add, WIDTH=8: a=0x35, b=0x4A, cin=0, then in_valid for 1 cycle -> out_valid high exactly 4 cycles after the accept edge, sum=0x7F, cout=0.
- Full carry ripple: a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1. Also a=0xFF, b=0xFF, cin=1 -> sum=0xFF, cout=1.
- Backpressure:
  - Hold out_ready=0 for 10 cycles after out_valid.
  - Required: sum/cout stable and in_ready=0 throughout, and in_valid with new operands is ignored.
  - Then raise out_ready -> IDLE next cycle.
- Abort: assert clear at the 2nd RUN cycle of a=0x12, b=0x34 -> IDLE next edge, and no out_valid ever appears. The next op a=0x01, b=0x02, cin=1 -> sum=0x04.
- Async reset mid-RUN: drop rst_n between clock edges during RUN -> outputs go to reset values immediately; after release, a fresh add a=0x80, b=0x80 -> sum=0x00, cout=1.

Source files
------------

// File: rtl/serial_adder_pkg.sv
// rtl/serial_adder_pkg.sv - shared state encoding and slice width for the serial adder
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int SLICE_W = 2;

endpackage

// File: rtl/two_bit_adder.sv
// rtl/two_bit_adder.sv - combinational 2-bit full adder slice
module two_bit_adder (
  input  logic [1:0] a,
  input  logic [1:0] b,
  input  logic       cin,
  output logic [1:0] sum,
  output logic       cout
);

  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {2'b00, cin};

endmodule

// File: rtl/serial_adder_ctrl.sv
// rtl/serial_adder_ctrl.sv - WIDTH-bit add with carry-in, two bits per cycle through one shared slice
module serial_adder_ctrl
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH/2) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             clear,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);

  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH/SLICE_W - 1);

  logic [1:0]         state;
  logic [WIDTH-1:0]   a_sh;
  logic [WIDTH-1:0]   b_sh;
  logic [WIDTH-1:0]   res;
  logic               carry;
  logic [CNT_W-1:0]   cnt;
  logic [SLICE_W-1:0] slice_sum;
  logic               slice_cout;
  logic [WIDTH-1:0]   res_next;

  two_bit_adder u_slice (
    .a    (a_sh[SLICE_W-1:0]),
    .b    (b_sh[SLICE_W-1:0]),
    .cin  (carry),
    .sum  (slice_sum),
    .cout (slice_cout)
  );

  // Each new pair enters at the top so the first (LSB) pair ends up at bit 0.
  if (WIDTH == SLICE_W) begin : g_res_single
    assign res_next = slice_sum;
  end else begin : g_res_shift
    assign res_next = {slice_sum, res[WIDTH-1:SLICE_W]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      a_sh  <= '0;
      b_sh  <= '0;
      res   <= '0;
      carry <= 1'b0;
      cnt   <= '0;
    end else if (clear) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_sh  <= a;
            b_sh  <= b;
            carry <= cin;
            res   <= '0;
            cnt   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          a_sh  <= a_sh >> SLICE_W;
          b_sh  <= b_sh >> SLICE_W;
          res   <= res_next;
          carry <= slice_cout;
          cnt   <= cnt + CNT_W'(1);
          if (cnt == LAST_STEP) state <= DONE;
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign sum       = res;
  assign cout      = carry;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// tb/tb_serial_adder_ctrl.sv - randomized self-checking bench for serial_adder_ctrl
module tb_serial_adder_ctrl;

  localparam int WIDTH = 8;
  localparam int STEPS = WIDTH / 2;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             clear;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             busy;

  int checks = 0;
  int errors = 0;

  serial_adder_ctrl #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .clear     (clear),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    if (obs !== expv) begin
      errors++;
      $display("FAIL %s got 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    while (in_ready !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    check({tag, "_ready_timeout"}, 32'(in_ready), 32'd1);
  endtask

  // Accept one operation, check exact latency, hold result for hold cycles, then hand off.
  task automatic do_add(input string tag, input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                        input logic cv, input int hold);
    logic [WIDTH:0]   model;
    logic [WIDTH-1:0] held_sum;
    logic             held_cout;
    model = {1'b0, av} + {1'b0, bv} + {{WIDTH{1'b0}}, cv};
    wait_ready(tag);
    a = av; b = bv; cin = cv; in_valid = 1'b1; out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    a = WIDTH'($urandom); b = WIDTH'($urandom); cin = 1'($urandom);
    check({tag, "_busy_run"}, 32'(busy), 32'd1);
    for (int i = 1; i < STEPS; i++) begin
      tick();
      check({tag, "_early_valid"}, 32'(out_valid), 32'd0);
    end
    tick();
    check({tag, "_out_valid"}, 32'(out_valid), 32'd1);
    check({tag, "_sum"}, 32'(sum), 32'(model[WIDTH-1:0]));
    check({tag, "_cout"}, 32'(cout), 32'(model[WIDTH]));
    held_sum = sum;
    held_cout = cout;
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1;
      a = WIDTH'($urandom); b = WIDTH'($urandom); cin = 1'($urandom);
      tick();
      check({tag, "_hold_valid"}, 32'(out_valid), 32'd1);
      check({tag, "_hold_ready"}, 32'(in_ready), 32'd0);
      check({tag, "_hold_sum"}, 32'({held_cout, sum}), 32'({held_cout, held_sum}));
      check({tag, "_hold_cout"}, 32'(cout), 32'(held_cout));
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, "_back_idle"}, 32'(in_ready), 32'd1);
    check({tag, "_valid_drop"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    logic [WIDTH-1:0] pre_sum;
    logic             pre_cout;
    logic             seen_valid;

    rst_n = 1'b0; clear = 1'b0; out_ready = 1'b0;
    in_valid = 1'b0; a = '0; b = '0; cin = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'($urandom); a = WIDTH'($urandom); b = WIDTH'($urandom);
      cin = 1'($urandom); out_ready = 1'($urandom); clear = 1'($urandom);
      tick();
      check("rst_in_ready", 32'(in_ready), 32'd1);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_sum", 32'(sum), 32'd0);
      check("rst_cout", 32'(cout), 32'd0);
    end
    in_valid = 1'b0; clear = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("post_rst_idle", 32'(in_ready), 32'd1);
    check("post_rst_busy", 32'(busy), 32'd0);

    do_add("basic", 8'h35, 8'h4A, 1'b0, 0);
    do_add("ripple", 8'hFF, 8'h01, 1'b0, 0);
    do_add("allones", 8'hFF, 8'hFF, 1'b1, 0);
    do_add("bp", 8'hA7, 8'h6C, 1'b1, 10);

    // Abort in the second RUN cycle.
    wait_ready("abort");
    a = 8'h12; b = 8'h34; cin = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    clear = 1'b1;
    pre_sum = sum;
    pre_cout = cout;
    tick();
    clear = 1'b0;
    check("abort_idle", 32'(in_ready), 32'd1);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_sum_kept", 32'(sum), 32'(pre_sum));
    check("abort_cout_kept", 32'(cout), 32'(pre_cout));
    seen_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (out_valid === 1'b1) seen_valid = 1'b1;
    end
    check("abort_no_valid", 32'(seen_valid), 32'd0);
    do_add("after_abort", 8'h01, 8'h02, 1'b1, 0);

    // clear beats in_valid in IDLE.
    a = 8'h55; b = 8'h11; in_valid = 1'b1; clear = 1'b1;
    tick();
    in_valid = 1'b0; clear = 1'b0;
    check("clear_vs_accept", 32'(in_ready), 32'd1);

    // Asynchronous reset between clock edges during RUN.
    wait_ready("arst");
    a = 8'hC3; b = 8'h5A; cin = 1'b1; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_in_ready", 32'(in_ready), 32'd1);
    check("arst_out_valid", 32'(out_valid), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_sum", 32'(sum), 32'd0);
    check("arst_cout", 32'(cout), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    do_add("after_arst", 8'h80, 8'h80, 1'b0, 0);

    for (int n = 0; n < 24; n++) begin
      do_add("rand", WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), int'($urandom_range(0, 3)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
